// File: rtl/cdc_hs_arbiter.sv
// Round-robin arbiter sharing one clk1->clk2 four-phase level handshake channel
// between NUM_REQ clk1-domain requesters; sits in front of the level synchronizers.
module cdc_hs_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic                       clk1,
  input  logic                       rst_n1,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DW-1:0]      req_data,
  input  logic                       ack_sync,
  output logic                       xfer_req,
  output logic [DW-1:0]              xfer_data,
  output logic [$clog2(NUM_REQ)-1:0] xfer_id,
  output logic [NUM_REQ-1:0]         done,
  output logic                       timeout_err,
  output logic                       busy
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_H = 2'd1,
    ST_WAIT_L = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [TO_W-1:0]     cnt, cnt_d;
  logic                to_flag, to_flag_d;
  logic [IW-1:0]       rr_ptr, rr_d;
  logic                xfer_req_d;
  logic [DW-1:0]       xfer_data_d;
  logic [IW-1:0]       xfer_id_d;
  logic [NUM_REQ-1:0]  done_d;
  logic                timeout_err_d;
  logic                busy_d;

  logic [DW-1:0]       payload [NUM_REQ];
  logic                found;
  logic [IW-1:0]       grant_idx;
  logic [CW-1:0]       cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign payload[g] = req_data[g*DW +: DW];
  end

  // First set request at or after the rr pointer, wrapping around.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = CW'(rr_ptr) + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!found && req[IW'(cand)]) begin
        found     = 1'b1;
        grant_idx = IW'(cand);
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n1) begin
    if (!rst_n1) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      to_flag     <= 1'b0;
      rr_ptr      <= '0;
      xfer_req    <= 1'b0;
      xfer_data   <= '0;
      xfer_id     <= '0;
      done        <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      to_flag     <= to_flag_d;
      rr_ptr      <= rr_d;
      xfer_req    <= xfer_req_d;
      xfer_data   <= xfer_data_d;
      xfer_id     <= xfer_id_d;
      done        <= done_d;
      timeout_err <= timeout_err_d;
      busy        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    to_flag_d     = to_flag;
    rr_d          = rr_ptr;
    xfer_req_d    = xfer_req;
    xfer_data_d   = xfer_data;
    xfer_id_d     = xfer_id;
    done_d        = '0;
    timeout_err_d = 1'b0;
    case (state)
      ST_IDLE: begin
        // A still-high ack from the previous transfer blocks new grants.
        if (found && !ack_sync) begin
          xfer_data_d = payload[grant_idx];
          xfer_id_d   = grant_idx;
          xfer_req_d  = 1'b1;
          cnt_d       = '0;
          to_flag_d   = 1'b0;
          state_d     = ST_WAIT_H;
        end
      end
      ST_WAIT_H: begin
        cnt_d = cnt + TO_W'(1);
        if (ack_sync) begin
          xfer_req_d = 1'b0;
          state_d    = ST_WAIT_L;
        end else if (cnt == TO_W'(TIMEOUT - 1)) begin
          xfer_req_d = 1'b0;
          to_flag_d  = 1'b1;
          state_d    = ST_WAIT_L;
        end
      end
      ST_WAIT_L: begin
        if (!ack_sync) begin
          done_d[xfer_id] = 1'b1;
          timeout_err_d   = to_flag;
          state_d         = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_d    = (xfer_id == IW'(NUM_REQ - 1)) ? '0 : xfer_id + IW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// Bench for cdc_hs_arbiter: directed and random transactions with an ack
// responder, checked against a transaction-level round-robin model.
module tb_cdc_hs_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned TO_W    = 8;
  localparam int unsigned TIMEOUT = 200;
  localparam int unsigned IW      = $clog2(N);

  logic              clk1 = 1'b0;
  logic              rst_n1;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic              ack_sync;
  logic              xfer_req;
  logic [DW-1:0]     xfer_data;
  logic [IW-1:0]     xfer_id;
  logic [N-1:0]      done;
  logic              timeout_err;
  logic              busy;

  int           n_chk  = 0;
  int           n_fail = 0;
  int           rr     = 0;
  logic [N-1:0] mask   = '0;

  always #5 clk1 = ~clk1;

  cdc_hs_arbiter #(.NUM_REQ(N), .DW(DW), .TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk1(clk1), .rst_n1(rst_n1), .req(req), .req_data(req_data),
    .ack_sync(ack_sync), .xfer_req(xfer_req), .xfer_data(xfer_data),
    .xfer_id(xfer_id), .done(done), .timeout_err(timeout_err), .busy(busy)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first pending requester at or after pointer p.
  function automatic int pick(input logic [N-1:0] m, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (m[IW'(j)]) return j;
    end
    return 0;
  endfunction

  task automatic scramble_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
  endtask

  // One complete transfer starting from an idle channel; leaves channel idle.
  task automatic run_xfer(input logic [N-1:0] add, input int stale, input bit no_ack,
                          input bit perturb, input bit force_d, input logic [DW-1:0] fdata);
    int            id;
    int            cnt;
    int            d_hi;
    int            d_lo;
    logic [DW-1:0] exp_d;
    logic [N-1:0]  keep;
    mask = mask | add;
    if (mask == '0) mask[0] = 1'b1;
    req = mask;
    scramble_data();
    id = pick(mask, rr);
    if (force_d) req_data[id*DW +: DW] = fdata;
    exp_d = req_data[id*DW +: DW];
    if (stale > 0) begin
      ack_sync = 1'b1;
      repeat (stale) begin
        tick();
        check("stale_no_grant", 32'(xfer_req), 32'd0);
      end
      ack_sync = 1'b0;
    end
    tick();
    check("grant_req", 32'(xfer_req), 32'd1);
    check("grant_busy", 32'(busy), 32'd1);
    check("grant_id", 32'(xfer_id), 32'(id));
    check("grant_data", 32'(xfer_data), 32'(exp_d));
    scramble_data();
    if (perturb) begin
      keep = N'($urandom) | (N'(1) << id);
      mask = (mask | N'($urandom)) & keep;
      req  = mask;
    end
    if (no_ack) begin
      cnt = 0;
      while (xfer_req === 1'b1 && cnt < 300) begin
        tick();
        cnt++;
      end
      check("timeout_len", 32'(cnt), 32'(TIMEOUT));
    end else begin
      d_hi = $urandom_range(1, 4);
      repeat (d_hi - 1) tick();
      check("wait_ack_req", 32'(xfer_req), 32'd1);
      ack_sync = 1'b1;
      tick();
      check("ack_drop_req", 32'(xfer_req), 32'd0);
      check("ack_no_done", 32'(done), 32'd0);
      d_lo = $urandom_range(1, 4);
      repeat (d_lo - 1) tick();
      ack_sync = 1'b0;
    end
    tick();
    check("done_onehot", 32'(done), 32'd1 << id);
    check("done_timeout", 32'(timeout_err), 32'(no_ack));
    check("done_busy", 32'(busy), 32'd1);
    check("hold_id", 32'(xfer_id), 32'(id));
    check("hold_data", 32'(xfer_data), 32'(exp_d));
    mask[IW'(id)] = 1'b0;
    req = mask;
    rr = (id + 1) % N;
    tick();
    check("post_done", 32'(done), 32'd0);
    check("post_timeout", 32'(timeout_err), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_req", 32'(xfer_req), 32'd0);
  endtask

  initial begin
    rst_n1   = 1'b0;
    req      = '0;
    req_data = '0;
    ack_sync = 1'b0;
    #2;
    check("rst_xfer_req", 32'(xfer_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_id", 32'(xfer_id), 32'd0);
    check("rst_data", 32'(xfer_data), 32'd0);
    repeat (2) tick();
    rst_n1 = 1'b1;

    // All four requesting: served 0,1,2,3.
    run_xfer(4'b1111, 0, 1'b0, 1'b0, 1'b0, '0);
    repeat (3) run_xfer(4'b0000, 0, 1'b0, 1'b0, 1'b0, '0);
    // Serve 1, then 0 and 1 pending: pointer at 2 wraps to 0, then 1.
    run_xfer(4'b0010, 0, 1'b0, 1'b0, 1'b0, '0);
    run_xfer(4'b0011, 0, 1'b0, 1'b0, 1'b0, '0);
    run_xfer(4'b0000, 0, 1'b0, 1'b0, 1'b0, '0);
    // Single requester 2 with fixed payload.
    run_xfer(4'b0100, 0, 1'b0, 1'b0, 1'b1, 8'hA5);
    // Ack never returns.
    run_xfer(4'b0001, 0, 1'b1, 1'b0, 1'b0, '0);
    // Stale ack held in idle.
    run_xfer(4'b0001, 3, 1'b0, 1'b0, 1'b0, '0);

    // Reset in WAIT_H with requesters 0 and 1 pending, pointer at 1.
    mask = mask | 4'b0011;
    req  = mask;
    tick();
    check("pre_rst_id", 32'(xfer_id), 32'(pick(mask, rr)));
    tick();
    rst_n1 = 1'b0;
    #1;
    check("midrst_xfer_req", 32'(xfer_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) tick();
    check("midrst_done_hold", 32'(done), 32'd0);
    rst_n1 = 1'b1;
    rr = 0;
    run_xfer(4'b0000, 0, 1'b0, 1'b0, 1'b0, '0);
    run_xfer(4'b0000, 0, 1'b0, 1'b0, 1'b0, '0);

    for (int t = 0; t < 40; t++) begin
      run_xfer(N'($urandom),
               ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
               ($urandom_range(0, 11) == 0),
               1'b1, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
